// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU: MIPS funct codes and a
// helper that says whether a code belongs to the supported operation set.
package alu_pkg;

  localparam logic [5:0] OP_SLL = 6'b000000;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SLT = 6'b101010;

  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// Combinational ALU core placed between the operand stage and the result
// stage. Unknown opcodes produce a zero result with Op_Invalid raised.
module alu_exec_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [5:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  overflow_o,
  output logic                  zero_o,
  output logic                  op_invalid_o
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0]        sum;
  logic [DATA_WIDTH-1:0]        diff;
  logic signed [DATA_WIDTH-1:0] a_signed;
  logic [SHW-1:0]               sh;
  logic                         add_ovf;
  logic                         sub_ovf;

  assign sum      = a_i + b_i;
  assign diff     = a_i - b_i;
  assign a_signed = a_i;
  // Only the low bits of B steer a shift; the rest are ignored.
  assign sh       = b_i[SHW-1:0];

  // Two's-complement overflow: sign of the result disagrees with what the
  // operand signs allow.
  assign add_ovf = (a_i[MSB] == b_i[MSB]) && (sum[MSB]  != a_i[MSB]);
  assign sub_ovf = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);

  // Operation select; overflow only reported for ADD/SUB.
  always_comb begin
    result_o   = '0;
    overflow_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o   = sum;
        overflow_o = add_ovf;
      end
      OP_SUB: begin
        result_o   = diff;
        overflow_o = sub_ovf;
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOR: result_o = ~(a_i | b_i);
      OP_SLL: result_o = a_i << sh;
      OP_SRL: result_o = a_i >> sh;
      OP_SRA: result_o = a_signed >>> sh;
      // Sign of A-B corrected by the subtract overflow keeps SLT exact.
      OP_SLT: result_o = {{(DATA_WIDTH-1){1'b0}}, diff[MSB] ^ sub_ovf};
      default: result_o = '0;
    endcase
  end

  assign zero_o       = (result_o == '0);
  assign op_invalid_o = !op_is_valid(op_i);

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ALU: stage 1 holds operands, stage 2 holds computed results.
// Owns the pipeline registers, the handshake and the sticky overflow flag.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [5:0]            Op,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  Zero,
  output logic                  Op_Invalid,
  output logic                  Ovf_Sticky,
  input  logic                  Ovf_Clear
);

  // Handshake: a beat moves across an interface on a rising edge where
  // valid && ready. Valid never depends combinationally on ready; In_Ready
  // is combinational so a full pipe still accepts one beat per clock while
  // the sink is draining.

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q;
  logic [DATA_WIDTH-1:0] s1_b_q;
  logic [5:0]            s1_op_q;

  logic                  s2_valid_q;
  logic [DATA_WIDTH-1:0] s2_result_q;
  logic                  s2_overflow_q;
  logic                  s2_zero_q;
  logic                  s2_invalid_q;

  logic                  sticky_q;
  logic                  sticky_d;

  logic [DATA_WIDTH-1:0] ex_result;
  logic                  ex_overflow;
  logic                  ex_zero;
  logic                  ex_invalid;

  logic                  s2_adv;
  logic                  s1_adv;

  // Stage 2 frees up when empty or its beat is taken; stage 1 frees up when
  // empty or its beat can move into stage 2.
  assign s2_adv   = !s2_valid_q || Out_Ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign In_Ready = s1_adv;

  alu_exec_comb #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_exec (
    .a_i          (s1_a_q),
    .b_i          (s1_b_q),
    .op_i         (s1_op_q),
    .result_o     (ex_result),
    .overflow_o   (ex_overflow),
    .zero_o       (ex_zero),
    .op_invalid_o (ex_invalid)
  );

  // Stage 1: capture operands whenever the stage is able to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= In_Valid;
      if (In_Valid) begin
        s1_a_q  <= A;
        s1_b_q  <= B;
        s1_op_q <= Op;
      end
    end
  end

  // Stage 2: register ALU outputs; contents hold while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_overflow_q <= 1'b0;
      s2_zero_q     <= 1'b0;
      s2_invalid_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q   <= ex_result;
        s2_overflow_q <= ex_overflow;
        s2_zero_q     <= ex_zero;
        s2_invalid_q  <= ex_invalid;
      end
    end
  end

  // Sticky overflow next state: an overflowing output transfer beats a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (Ovf_Clear) begin
      sticky_d = 1'b0;
    end
    if (s2_valid_q && Out_Ready && s2_overflow_q) begin
      sticky_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign Out_Valid  = s2_valid_q;
  assign Result     = s2_result_q;
  assign Overflow   = s2_overflow_q;
  assign Zero       = s2_zero_q;
  assign Op_Invalid = s2_invalid_q;
  assign Ovf_Sticky = sticky_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu: directed scenarios with literal expectations plus
// a randomized run, all outputs checked against a behavioural model.
module tb_pipelined_alu;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       In_Valid, In_Ready, Out_Valid, Out_Ready;
  logic [7:0] A, B, Result;
  logic [5:0] Op;
  logic       Overflow, Zero, Op_Invalid, Ovf_Sticky, Ovf_Clear;

  logic        v32_in, r32_in, v32_out, ovf32, z32, inv32, st32;
  logic [31:0] a32, b32, res32;
  logic [5:0]  op32;

  pipelined_alu #(.DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .A(A), .B(B), .Op(Op), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Result(Result), .Overflow(Overflow), .Zero(Zero), .Op_Invalid(Op_Invalid),
    .Ovf_Sticky(Ovf_Sticky), .Ovf_Clear(Ovf_Clear)
  );

  pipelined_alu #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .In_Valid(v32_in), .In_Ready(r32_in),
    .A(a32), .B(b32), .Op(op32), .Out_Valid(v32_out), .Out_Ready(1'b1),
    .Result(res32), .Overflow(ovf32), .Zero(z32), .Op_Invalid(inv32),
    .Ovf_Sticky(st32), .Ovf_Clear(1'b0)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packed as {op_invalid, zero, overflow, result[7:0]}.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    int sa, sb, ua, sh, r;
    logic [7:0] res;
    logic ovf, inv;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    sh = int'(b) % 8;
    ovf = 1'b0;
    inv = 1'b0;
    r = 0;
    case (op)
      OP_ADD: begin r = sa + sb; ovf = (r > 127) || (r < -128); end
      OP_SUB: begin r = sa - sb; ovf = (r > 127) || (r < -128); end
      OP_AND: r = int'(a & b);
      OP_OR:  r = int'(a | b);
      OP_XOR: r = int'(a ^ b);
      OP_NOR: r = 255 - int'(a | b);
      OP_SLL: r = ua * (2 ** sh);
      OP_SRL: r = ua / (2 ** sh);
      OP_SRA: r = sa >>> sh;
      OP_SLT: r = (sa < sb) ? 1 : 0;
      default: inv = 1'b1;
    endcase
    res = r[7:0];
    return {inv, (res == 8'h00), ovf, res};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [10:0] exp_q[$];
  logic [7:0]  out_log[$];
  int          acc_cnt = 0;
  logic        model_sticky = 1'b0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out;

  // Sampled on the falling edge: values here decide the next rising edge.
  always @(negedge clk) begin
    logic [10:0] e;
    logic nxt;
    if (!rst_n) begin
      exp_q.delete();
      model_sticky = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("sticky", {31'd0, Ovf_Sticky}, {31'd0, model_sticky});
      if (prev_stall)
        chk("hold", {20'd0, Out_Valid, Op_Invalid, Zero, Overflow, Result}, {20'd0, 1'b1, prev_out});
      if (exp_q.size() == 0)
        chk("spurious_valid", {31'd0, Out_Valid}, 32'd0);
      nxt = model_sticky;
      if (Ovf_Clear) nxt = 1'b0;
      if (Out_Valid && Out_Ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_beat", {21'd0, Op_Invalid, Zero, Overflow, Result}, {21'd0, e});
        out_log.push_back(Result);
        if (e[8]) nxt = 1'b1;
      end
      model_sticky = nxt;
      prev_stall = Out_Valid && !Out_Ready;
      prev_out = {Op_Invalid, Zero, Overflow, Result};
      if (In_Valid && In_Ready) begin
        exp_q.push_back(model(A, B, Op));
        acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offer a beat and return just after the edge that accepted it.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    bit ok;
    In_Valid = 1'b1; A = a; B = b; Op = op;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (In_Ready) ok = 1;
    end
    chk("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Single beat with the sink ready; captures the output beat.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         output logic [10:0] got);
    bit seen;
    drive(a, b, op);
    In_Valid = 1'b0;
    seen = 0;
    got = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (Out_Valid && Out_Ready) begin
        got = {Op_Invalid, Zero, Overflow, Result};
        seen = 1;
      end
    end
    chk("output_timeout", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_tbl [12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
                              OP_SLL, OP_SRL, OP_SRA, OP_SLT, 6'b000001, 6'b111111};

  initial begin
    logic [10:0] g;
    bit acc, done;
    int base;
    In_Valid = 0; A = 0; B = 0; Op = 0; Out_Ready = 1; Ovf_Clear = 0;
    v32_in = 0; a32 = 0; b32 = 0; op32 = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
    chk("rst_flags", {27'd0, Result == 8'h00, Overflow, Zero, Op_Invalid, Ovf_Sticky}, 32'h10);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, In_Ready}, 32'd1);
    @(posedge clk); #1;

    // 1: back-to-back ADD overflow then SUB zero.
    drive(8'h7F, 8'h01, OP_ADD);
    drive(8'h05, 8'h05, OP_SUB);
    In_Valid = 0;
    chk("t1_first", {22'd0, Out_Valid, Result, Overflow, Zero}, {22'd0, 1'b1, 8'h80, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("t1_second", {22'd0, Out_Valid, Result, Overflow, Zero}, {22'd0, 1'b1, 8'h00, 1'b0, 1'b1});
    chk("t1_sticky", {31'd0, Ovf_Sticky}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // 2: stalled sink with four beats offered.
    Out_Ready = 0;
    out_log.delete();
    base = acc_cnt;
    fork
      begin
        drive(8'd1, 8'd1, OP_ADD); drive(8'd2, 8'd2, OP_ADD);
        drive(8'd3, 8'd3, OP_ADD); drive(8'd4, 8'd4, OP_ADD);
        In_Valid = 0;
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("t2_accepted", acc_cnt - base, 32'd2);
        chk("t2_in_ready", {31'd0, In_Ready}, 32'd0);
        chk("t2_held", {23'd0, Out_Valid, Result}, {23'd0, 1'b1, 8'h02});
        Out_Ready = 1;
      end
    join
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      if (out_log.size() >= 4 && exp_q.size() == 0) done = 1;
    end
    #1;
    chk("t2_count", out_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk("t2_order", {24'd0, out_log[i]}, 32'(2 * (i + 1)));

    // 3: shifts.
    run_one(8'h80, 8'h03, OP_SRA, g); chk("sra_80_3", {21'd0, g}, {21'd0, 3'b000, 8'hF0});
    run_one(8'h80, 8'h07, OP_SRL, g); chk("srl_80_7", {21'd0, g}, {21'd0, 3'b000, 8'h01});
    run_one(8'h01, 8'h07, OP_SLL, g); chk("sll_01_7", {21'd0, g}, {21'd0, 3'b000, 8'h80});
    run_one(8'hA5, 8'hF8, OP_SRL, g); chk("srl_sh0", {21'd0, g}, {21'd0, 3'b000, 8'hA5});

    // 3b: 32-bit instance, SRA by 31.
    v32_in = 1; a32 = 32'h8000_0000; b32 = 32'd31; op32 = OP_SRA;
    @(negedge clk);
    chk("w32_ready", {31'd0, r32_in}, 32'd1);
    @(posedge clk); #1;
    v32_in = 0;
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (v32_out) done = 1;
    end
    chk("w32_valid", {31'd0, done}, 32'd1);
    chk("w32_sra", res32, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // 4: SLT including the overflow case.
    run_one(8'h80, 8'h7F, OP_SLT, g); chk("slt_80_7f", {21'd0, g}, {21'd0, 3'b000, 8'h01});
    run_one(8'h7F, 8'h80, OP_SLT, g); chk("slt_7f_80", {21'd0, g}, {21'd0, 3'b010, 8'h00});
    run_one(8'hFF, 8'hFF, OP_SLT, g); chk("slt_ff_ff", {21'd0, g}, {21'd0, 3'b010, 8'h00});

    // 5: invalid op, then clear colliding with an overflowing transfer.
    run_one(8'hAA, 8'h55, 6'b000001, g); chk("invalid_op", {21'd0, g}, {21'd0, 3'b110, 8'h00});
    Ovf_Clear = 1;
    @(posedge clk); #1;
    Ovf_Clear = 0;
    chk("t5_cleared", {31'd0, Ovf_Sticky}, 32'd0);
    drive(8'h7F, 8'h7F, OP_ADD);
    In_Valid = 0;
    @(posedge clk); #1;
    chk("t5_out_valid", {31'd0, Out_Valid}, 32'd1);
    Ovf_Clear = 1;
    @(posedge clk); #1;
    Ovf_Clear = 0;
    chk("t5_set_wins", {31'd0, Ovf_Sticky}, 32'd1);
    repeat (2) @(posedge clk); #1;

    // 6: asynchronous reset with two beats in flight.
    Out_Ready = 0;
    drive(8'h10, 8'h20, OP_ADD);
    drive(8'h30, 8'h40, OP_OR);
    In_Valid = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("t6_valid_rst", {31'd0, Out_Valid}, 32'd0);
    chk("t6_sticky_rst", {31'd0, Ovf_Sticky}, 32'd0);
    exp_q.delete();
    model_sticky = 0;
    repeat (2) @(posedge clk); #3;
    rst_n = 1;
    Out_Ready = 1;
    done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Out_Valid) done = 1;
    end
    chk("t6_nothing_emitted", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    run_one(8'h03, 8'h04, OP_XOR, g); chk("t6_after", {21'd0, g}, {21'd0, 3'b000, 8'h07});

    // Randomized traffic; the compare process checks every transfer.
    acc = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      acc = In_Valid && In_Ready;
      @(posedge clk); #1;
      if (!In_Valid || acc) begin
        In_Valid = ($urandom_range(0, 3) != 0);
        A = ($urandom_range(0, 3) == 0) ? 8'h7F + 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
        Op = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : op_tbl[$urandom_range(0, 11)];
      end
      Out_Ready = ($urandom_range(0, 3) != 0);
      Ovf_Clear = ($urandom_range(0, 7) == 0);
    end
    In_Valid = 0;
    Out_Ready = 1;
    Ovf_Clear = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1;
    end
    #1;
    chk("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
